// File: rtl/chi_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chi_link_pkg
//  Description : Shared types and constants for the CHI REQ link transmitter:
//                link state, request flit layout, credit-return opcode and
//                the credit-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package chi_link_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        RETURN = 2'd1,
        STOP   = 2'd2
    } link_state_e;

    // Credit-return flits carry this opcode with every other field zero.
    localparam logic [5:0] REQ_LCRD_RETURN = 6'd0;

    // CHI allows a transmitter to hold at most 15 link credits.
    localparam int CRD_MAX_DEF = 15;

    // Request flit layout.  This is the local copy of the layout that the
    // wider CHI environment keeps in its shared interface header.
    typedef struct packed {
        logic [15:0] addr;
        logic [6:0]  srcid;
        logic [6:0]  tgtid;
        logic [7:0]  txnid;
        logic [5:0]  opcode;
    } reqflit_t;

    // Number of bits needed to count 0..max_crd credits.
    function automatic int crd_width(input int max_crd);
        return $clog2(max_crd + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chi_req_tx_link_if.sv
`default_nettype none
// ============================================================================
//  Module      : chi_req_tx_link_if
//  Description : Protocol-side request handshake plus the TXREQ link-side
//                flit/credit wires.  The link transmitter uses the slave view;
//                the protocol layer / receiver side uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface chi_req_tx_link_if;
    import chi_link_pkg::*;

    logic     req_valid;
    reqflit_t req;
    logic     req_ready;
    reqflit_t TXREQFLIT;
    logic     TXREQFLITV;
    logic     TXREQFLITPEND;
    logic     TXREQLCRDV;

    modport slave (
        input  req_valid, req, TXREQLCRDV,
        output req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
    );

    modport master (
        output req_valid, req, TXREQLCRDV,
        input  req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
    );

endinterface
`default_nettype wire

// File: rtl/chi_flit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : chi_flit_fifo
//  Description : Synchronous FIFO, element type and depth parameterised,
//                with first-word fall-through head and an occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module chi_flit_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire T                           i_data,
    input  wire logic                       i_pop,
    output T                                o_head,
    output logic [$clog2(DEPTH+1)-1:0]      o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // Never overrun or underrun, even if the caller misbehaves.
    assign w_push  = i_push && (r_count != c_full);
    assign w_pop   = i_pop  && (r_count != '0);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/chi_req_tx_link.sv
`default_nettype none
// ============================================================================
//  Module      : chi_req_tx_link
//  Description : CHI REQ link-layer transmitter.  Queues protocol flits,
//                spends receiver-granted L-credits, announces each flit one
//                cycle early on TXREQFLITPEND and returns all held credits
//                when the link is deactivated.
//  Revision    : 1.0 - initial release
// ============================================================================
module chi_req_tx_link
    import chi_link_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CRD_MAX = CRD_MAX_DEF
) (
    input  wire logic            clock,
    input  wire logic            reset,
    chi_req_tx_link_if.slave     txreq,
    input  wire logic            link_deact,
    output logic                 link_idle,
    output logic                 crd_overflow
);
    localparam int CW = crd_width(CRD_MAX);
    localparam int QW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_crd_max = CW'(CRD_MAX);
    localparam logic [QW-1:0] c_q_full  = QW'(DEPTH);

    link_state_e     r_state;
    logic [CW-1:0]   r_crd;
    logic            r_ovf;
    reqflit_t        r_flit;
    logic            r_flitv;
    logic [QW-1:0]   w_q;
    reqflit_t        w_head;
    reqflit_t        w_lcrd_ret;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;

    // Ready depends only on registered state, never on req_valid.
    assign txreq.req_ready = (r_state == RUN) && !link_deact && (w_q != c_q_full);
    assign w_push          = txreq.req_valid && txreq.req_ready;
    assign w_pop           = w_fire && (r_state == RUN);

    assign txreq.TXREQFLIT     = r_flit;
    assign txreq.TXREQFLITV    = r_flitv;
    assign txreq.TXREQFLITPEND = w_fire;
    assign link_idle           = (r_state == STOP);
    assign crd_overflow        = r_ovf;

    chi_flit_fifo #(
        .DEPTH (DEPTH),
        .T     (reqflit_t)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (txreq.req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_q)
    );

    // Fire decision: a flit goes out whenever there is something to send and a credit to spend it.
    always_comb begin
        w_fire     = 1'b0;
        w_lcrd_ret = '0;
        w_lcrd_ret.opcode = REQ_LCRD_RETURN;
        case (r_state)
            RUN:     w_fire = (w_q != '0) && (r_crd != '0);
            RETURN:  w_fire = (r_crd != '0);
            default: w_fire = 1'b0;
        endcase
    end

    // Credit counter: spend on fire, gain on TXREQLCRDV, saturate with sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_crd <= '0;
            r_ovf <= 1'b0;
        end else begin
            case ({w_fire, txreq.TXREQLCRDV})
                2'b10: r_crd <= r_crd - 1'b1;
                2'b01: begin
                    if (r_crd == c_crd_max) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_crd <= r_crd + 1'b1;
                    end
                end
                default: r_crd <= r_crd;
            endcase
        end
    end

    // Link FSM with registered flit outputs; RETURN always runs to completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
            r_flit  <= '0;
            r_flitv <= 1'b0;
        end else begin
            r_flitv <= w_fire;
            if (w_fire) begin
                r_flit <= (r_state == RUN) ? w_head : w_lcrd_ret;
            end
            case (r_state)
                RUN: begin
                    if (link_deact && (w_q == '0) && !w_fire) r_state <= RETURN;
                end
                RETURN: begin
                    if ((r_crd == '0) && !txreq.TXREQLCRDV) r_state <= STOP;
                end
                STOP: begin
                    if (!link_deact) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule
`default_nettype wire
